// File: rtl/led_adc_sequencer.sv
// led_adc_sequencer
// Alternates the red and IR finger-clip LEDs in fixed-length phases. In each
// phase it waits for the LED to settle, requests one ADC conversion and holds
// the result for the downstream red/IR FIR filters.
//
// Ports
//   CLK_Filter       in   system clock, rising edge
//   rst_n            in   asynchronous active-low reset
//   Seq_En           in   1 = run the LED/ADC sequence, 0 = go idle
//   Err_Clr          in   clears ADC_Timeout_Err (a new timeout wins)
//   ADC_Done         in   one-cycle conversion-complete pulse
//   ADC_Data[7:0]    in   conversion result, valid with ADC_Done
//   ADC_Start        out  one-cycle conversion request
//   LED_RED, LED_IR  out  LED drives, never both on
//   RED_ADC_Value    out  last captured red sample
//   IR_ADC_Value     out  last captured IR sample
//   RED_Valid        out  one-cycle pulse when RED_ADC_Value updates
//   IR_Valid         out  one-cycle pulse when IR_ADC_Value updates
//   ADC_Timeout_Err  out  sticky flag, set when a conversion never completes
module led_adc_sequencer #(
    parameter int unsigned PHASE_CYC   = 5000,
    parameter int unsigned SETTLE_CYC  = 500,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic       CLK_Filter,
    input  logic       rst_n,
    input  logic       Seq_En,
    input  logic       Err_Clr,
    input  logic       ADC_Done,
    input  logic [7:0] ADC_Data,
    output logic       ADC_Start,
    output logic       LED_RED,
    output logic       LED_IR,
    output logic [7:0] RED_ADC_Value,
    output logic [7:0] IR_ADC_Value,
    output logic       RED_Valid,
    output logic       IR_Valid,
    output logic       ADC_Timeout_Err
);

    localparam int unsigned CNT_W  = $clog2(PHASE_CYC);
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PHASE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_SETTLE = CNT_W'(SETTLE_CYC);
    // The Start cycle plus TIMEOUT_CYC-1 CONV cycles form the response
    // window; the wait counter reads 0 in the first CONV cycle.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 2);

    typedef enum logic [2:0] {
        IDLE,
        RED_SETTLE,
        RED_CONV,
        RED_HOLD,
        IR_SETTLE,
        IR_CONV,
        IR_HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  phase_cnt_q, phase_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic       cap_red, cap_ir, timeout;
    logic       red_phase_d, ir_phase_d;
    logic       start_d, led_red_d, led_ir_d;
    logic [7:0] red_val_d, ir_val_d;
    logic       red_valid_d, ir_valid_d, err_d;

    // State, counters and all outputs are registered together.
    always_ff @(posedge CLK_Filter or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            phase_cnt_q     <= '0;
            wait_cnt_q      <= '0;
            ADC_Start       <= 1'b0;
            LED_RED         <= 1'b0;
            LED_IR          <= 1'b0;
            RED_ADC_Value   <= '0;
            IR_ADC_Value    <= '0;
            RED_Valid       <= 1'b0;
            IR_Valid        <= 1'b0;
            ADC_Timeout_Err <= 1'b0;
        end else begin
            state_q         <= state_d;
            phase_cnt_q     <= phase_cnt_d;
            wait_cnt_q      <= wait_cnt_d;
            ADC_Start       <= start_d;
            LED_RED         <= led_red_d;
            LED_IR          <= led_ir_d;
            RED_ADC_Value   <= red_val_d;
            IR_ADC_Value    <= ir_val_d;
            RED_Valid       <= red_valid_d;
            IR_Valid        <= ir_valid_d;
            ADC_Timeout_Err <= err_d;
        end
    end

    // Next state and next register values.
    always_comb begin
        state_d     = state_q;
        phase_cnt_d = (phase_cnt_q == CNT_LAST) ? '0 : phase_cnt_q + CNT_W'(1);
        wait_cnt_d  = '0;
        cap_red     = 1'b0;
        cap_ir      = 1'b0;
        timeout     = 1'b0;

        if (!Seq_En) begin
            // Abandons any pending conversion; values and error flag persist.
            state_d     = IDLE;
            phase_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d     = RED_SETTLE;
                    phase_cnt_d = '0;
                end
                RED_SETTLE: if (phase_cnt_q == CNT_SETTLE) state_d = RED_CONV;
                RED_CONV: begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    if (ADC_Done) begin
                        cap_red = 1'b1;
                        state_d = RED_HOLD;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        timeout = 1'b1;
                        state_d = RED_HOLD;
                    end
                end
                RED_HOLD: if (phase_cnt_q == CNT_LAST) state_d = IR_SETTLE;
                IR_SETTLE: if (phase_cnt_q == CNT_SETTLE) state_d = IR_CONV;
                IR_CONV: begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    if (ADC_Done) begin
                        cap_ir  = 1'b1;
                        state_d = IR_HOLD;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        timeout = 1'b1;
                        state_d = IR_HOLD;
                    end
                end
                IR_HOLD: if (phase_cnt_q == CNT_LAST) state_d = RED_SETTLE;
                default: state_d = IDLE;
            endcase
        end

        // Outputs are derived from the next state so they line up with it.
        red_phase_d = (state_d == RED_SETTLE) || (state_d == RED_CONV) ||
                      (state_d == RED_HOLD);
        ir_phase_d  = (state_d == IR_SETTLE) || (state_d == IR_CONV) ||
                      (state_d == IR_HOLD);
        // Count 0 of every phase is the break-before-make dead cycle.
        led_red_d   = red_phase_d && (phase_cnt_d != '0);
        led_ir_d    = ir_phase_d && (phase_cnt_d != '0);
        start_d     = ((state_d == RED_SETTLE) || (state_d == IR_SETTLE)) &&
                      (phase_cnt_d == CNT_SETTLE);

        red_val_d   = cap_red ? ADC_Data : RED_ADC_Value;
        ir_val_d    = cap_ir ? ADC_Data : IR_ADC_Value;
        red_valid_d = cap_red;
        ir_valid_d  = cap_ir;
        // A timeout in the same cycle as Err_Clr leaves the flag set.
        err_d       = timeout ? 1'b1 : (Err_Clr ? 1'b0 : ADC_Timeout_Err);
    end

endmodule
